// File: rtl/cl_axil_arb2_if.sv
// AXI-Lite subset bus between the arbiter and its neighbours.
// 'master' is the arbiter's view of an upstream requester; 'slave' its view of the downstream target.
interface axi_bus_t;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/cl_axil_arb2.sv
// Two-requester round-robin AXI-Lite arbiter, one transaction outstanding downstream at a time.
// Optional CL_AXIL_ARB_DECERR_EN: out-of-window requests are answered locally with DECERR.
module cl_axil_arb2 #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0001_0000
) (
    input  logic       clk,
    input  logic       sync_rst_n,
    axi_bus_t.master   s0_axi_bus,
    axi_bus_t.master   s1_axi_bus,
    axi_bus_t.slave    m_axi_bus,
    output logic [1:0] grant,
    output logic       busy
);

    if ((ADDR_SIZE & (ADDR_SIZE - 32'd1)) != 32'd0 || (ADDR_BASE & (ADDR_SIZE - 32'd1)) != 32'd0) begin : g_bad_window
        $error("cl_axil_arb2: ADDR_SIZE must be a power of two and ADDR_BASE aligned to it");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD,
        RD_RESP
`ifdef CL_AXIL_ARB_DECERR_EN
        , LOC_WR,
        LOC_RD
`endif
    } state_t;

    state_t state, state_nxt;
    logic   sel, sel_nxt, last_gnt, aw_done, w_done;
    logic   aw_fire, w_fire;

    logic wr0, wr1, req0, req1, win, win_wr;
    assign wr0    = s0_axi_bus.awvalid & s0_axi_bus.wvalid;
    assign wr1    = s1_axi_bus.awvalid & s1_axi_bus.wvalid;
    assign req0   = wr0 | s0_axi_bus.arvalid;
    assign req1   = wr1 | s1_axi_bus.arvalid;
    assign win    = (req0 & req1) ? ~last_gnt : req1;
    assign win_wr = win ? wr1 : wr0;

    logic        g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
    logic [31:0] g_awaddr, g_wdata, g_araddr;
    logic [3:0]  g_wstrb;
    assign g_awvalid = sel ? s1_axi_bus.awvalid : s0_axi_bus.awvalid;
    assign g_wvalid  = sel ? s1_axi_bus.wvalid  : s0_axi_bus.wvalid;
    assign g_bready  = sel ? s1_axi_bus.bready  : s0_axi_bus.bready;
    assign g_arvalid = sel ? s1_axi_bus.arvalid : s0_axi_bus.arvalid;
    assign g_rready  = sel ? s1_axi_bus.rready  : s0_axi_bus.rready;
    assign g_awaddr  = sel ? s1_axi_bus.awaddr  : s0_axi_bus.awaddr;
    assign g_wdata   = sel ? s1_axi_bus.wdata   : s0_axi_bus.wdata;
    assign g_araddr  = sel ? s1_axi_bus.araddr  : s0_axi_bus.araddr;
    assign g_wstrb   = sel ? s1_axi_bus.wstrb   : s0_axi_bus.wstrb;

`ifdef CL_AXIL_ARB_DECERR_EN
    logic [31:0] win_awaddr, win_araddr;
    assign win_awaddr = win ? s1_axi_bus.awaddr : s0_axi_bus.awaddr;
    assign win_araddr = win ? s1_axi_bus.araddr : s0_axi_bus.araddr;

    // Unsigned offset from the base: addresses below ADDR_BASE wrap and fail too.
    function automatic logic in_window(input logic [31:0] a);
        return (a - ADDR_BASE) < ADDR_SIZE;
    endfunction
`endif

    // Responses toward the granted requester, steered by sel below.
    logic        up_awready, up_wready, up_bvalid, up_arready, up_rvalid;
    logic [1:0]  up_bresp, up_rresp;
    logic [31:0] up_rdata;

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        aw_fire    = 1'b0;
        w_fire     = 1'b0;
        up_awready = 1'b0;
        up_wready  = 1'b0;
        up_bvalid  = 1'b0;
        up_bresp   = '0;
        up_arready = 1'b0;
        up_rvalid  = 1'b0;
        up_rdata   = '0;
        up_rresp   = '0;
        m_axi_bus.awaddr  = '0;
        m_axi_bus.awvalid = 1'b0;
        m_axi_bus.wdata   = '0;
        m_axi_bus.wstrb   = '0;
        m_axi_bus.wvalid  = 1'b0;
        m_axi_bus.bready  = 1'b0;
        m_axi_bus.araddr  = '0;
        m_axi_bus.arvalid = 1'b0;
        m_axi_bus.rready  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    sel_nxt = win;
`ifdef CL_AXIL_ARB_DECERR_EN
                    if (win_wr) state_nxt = in_window(win_awaddr) ? WR : LOC_WR;
                    else        state_nxt = in_window(win_araddr) ? RD : LOC_RD;
`else
                    state_nxt = win_wr ? WR : RD;
`endif
                end
            end
            WR: begin
                m_axi_bus.awaddr  = g_awaddr;
                m_axi_bus.wdata   = g_wdata;
                m_axi_bus.wstrb   = g_wstrb;
                m_axi_bus.awvalid = g_awvalid & ~aw_done;
                m_axi_bus.wvalid  = g_wvalid & ~w_done;
                up_awready = m_axi_bus.awready & ~aw_done;
                up_wready  = m_axi_bus.wready & ~w_done;
                aw_fire    = m_axi_bus.awvalid & m_axi_bus.awready;
                w_fire     = m_axi_bus.wvalid & m_axi_bus.wready;
                if ((aw_done | aw_fire) & (w_done | w_fire)) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                m_axi_bus.bready = g_bready;
                up_bvalid = m_axi_bus.bvalid;
                up_bresp  = m_axi_bus.bresp;
                if (m_axi_bus.bvalid & g_bready) state_nxt = IDLE;
            end
            RD: begin
                m_axi_bus.araddr  = g_araddr;
                m_axi_bus.arvalid = g_arvalid;
                up_arready = m_axi_bus.arready;
                if (g_arvalid & m_axi_bus.arready) state_nxt = RD_RESP;
            end
            RD_RESP: begin
                m_axi_bus.rready = g_rready;
                up_rvalid = m_axi_bus.rvalid;
                up_rdata  = m_axi_bus.rdata;
                up_rresp  = m_axi_bus.rresp;
                if (m_axi_bus.rvalid & g_rready) state_nxt = IDLE;
            end
`ifdef CL_AXIL_ARB_DECERR_EN
            LOC_WR: begin
                up_awready = ~aw_done;
                up_wready  = ~w_done;
                aw_fire    = g_awvalid & ~aw_done;
                w_fire     = g_wvalid & ~w_done;
                up_bvalid  = aw_done & w_done;
                up_bresp   = {2{up_bvalid}};
                if (up_bvalid & g_bready) state_nxt = IDLE;
            end
            // aw_done doubles as the "AR accepted" flag here.
            LOC_RD: begin
                up_arready = ~aw_done;
                aw_fire    = g_arvalid & ~aw_done;
                up_rvalid  = aw_done;
                up_rresp   = {2{aw_done}};
                if (aw_done & g_rready) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state    <= IDLE;
            sel      <= 1'b0;
            last_gnt <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            if (state != IDLE && state_nxt == IDLE) last_gnt <= sel;
            if (state_nxt != state) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_fire) aw_done <= 1'b1;
                if (w_fire)  w_done  <= 1'b1;
            end
        end
    end

    assign busy  = (state != IDLE);
    assign grant = busy ? (sel ? 2'b10 : 2'b01) : 2'b00;

    assign s0_axi_bus.awready = ~sel & up_awready;
    assign s0_axi_bus.wready  = ~sel & up_wready;
    assign s0_axi_bus.bvalid  = ~sel & up_bvalid;
    assign s0_axi_bus.bresp   = sel ? 2'b00 : up_bresp;
    assign s0_axi_bus.arready = ~sel & up_arready;
    assign s0_axi_bus.rvalid  = ~sel & up_rvalid;
    assign s0_axi_bus.rdata   = sel ? 32'h0 : up_rdata;
    assign s0_axi_bus.rresp   = sel ? 2'b00 : up_rresp;

    assign s1_axi_bus.awready = sel & up_awready;
    assign s1_axi_bus.wready  = sel & up_wready;
    assign s1_axi_bus.bvalid  = sel & up_bvalid;
    assign s1_axi_bus.bresp   = sel ? up_bresp : 2'b00;
    assign s1_axi_bus.arready = sel & up_arready;
    assign s1_axi_bus.rvalid  = sel & up_rvalid;
    assign s1_axi_bus.rdata   = sel ? up_rdata : 32'h0;
    assign s1_axi_bus.rresp   = sel ? up_rresp : 2'b00;

endmodule

// File: doc/cl_axil_arb2.md
CL_AXIL_ARB2 -- requirements
Module: cl_axil_arb2

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000: lowest legal downstream address, used only with CL_AXIL_ARB_DECERR_EN.
REQ-002 SHALL have parameter ADDR_SIZE, default 32'h0001_0000: legal window size in bytes, a power of two; window is [ADDR_BASE, ADDR_BASE+ADDR_SIZE).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port sync_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port s0_axi_bus, axi_bus_t.master, AXI-Lite subset: requester 0 (upstream).
REQ-006 SHALL have port s1_axi_bus, axi_bus_t.master, AXI-Lite subset: requester 1 (upstream).
REQ-007 SHALL have port m_axi_bus, axi_bus_t.slave, AXI-Lite subset: shared downstream target.
REQ-008 The AXI-Lite subset on each bus SHALL be awaddr[31:0], awvalid/awready, wdata[31:0], wstrb[3:0], wvalid/wready, bresp[1:0], bvalid/bready, araddr[31:0], arvalid/arready, rdata[31:0], rresp[1:0], rvalid/rready. All other interface fields are tied to 0.
REQ-009 SHALL have port grant, output, 2 bits: one-hot owner of the downstream bus; 2'b00 when idle.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 SHALL use the FSM states IDLE, WR, WR_RESP, RD and RD_RESP, plus LOC_WR and LOC_RD when CL_AXIL_ARB_DECERR_EN is defined.
REQ-012 A requester's write request SHALL be awvalid & wvalid; its read request SHALL be arvalid.
REQ-013 In IDLE, arbitration SHALL be round-robin between requesters: if both request, the requester not in register last_gnt wins.
REQ-014 When the winning requester requests both a write and a read, the write SHALL be granted first.
REQ-015 The grant SHALL be registered: a request seen in IDLE at cycle N gives state WR or RD at cycle N+1, and m_*valid is asserted at cycle N+1 at the earliest.
REQ-016 In WR: m_awvalid = s_awvalid & ~aw_done, and m_wvalid = s_wvalid & ~w_done; the granted s_awready/s_wready SHALL follow m_awready/m_wready combinationally.
REQ-017 In WR: AW and W SHALL complete independently, each setting its own done flag; the FSM moves to WR_RESP in the cycle after both are done, including when both complete in the same cycle.
REQ-018 In WR_RESP: m_bready = granted s_bready, and the granted s_bvalid/s_bresp = m_bvalid/m_bresp; on handshake the FSM returns to IDLE and updates last_gnt.
REQ-019 In RD: m_arvalid = granted s_arvalid; on handshake the FSM moves to RD_RESP. In RD_RESP, r is forwarded the same way as b, returning to IDLE on handshake.
REQ-020 Each downstream address and data field SHALL be a combinational mux of the granted requester's fields.
REQ-021 Every ready/valid toward a non-granted requester SHALL be 0, and all m_*valid/m_*ready SHALL be 0 in IDLE.
REQ-022 At most one transaction SHALL be outstanding downstream at a time; back-to-back transactions cost one IDLE cycle between them.
REQ-023 Upstream valids SHALL never be dropped: a losing request simply stays pending.

Reset
REQ-024 When sync_rst_n=0 at a clock edge, the FSM SHALL go to IDLE, last_gnt=1 (so s0 wins the first tie), and aw_done=w_done=0.
REQ-025 After reset, all outputs SHALL be 0: grant=2'b00, busy=0, and every valid/ready/resp/data output 0.
REQ-026 Reset during any state SHALL abort the transaction with no completion issued; the environment resets both sides together.

Configuration
REQ-027 When CL_AXIL_ARB_DECERR_EN is defined, a granted request whose address is outside the window SHALL go to LOC_WR or LOC_RD instead of WR or RD, and SHALL never reach m_axi_bus.
REQ-028 In LOC_WR, the block SHALL itself assert awready and wready (independent done flags), then bvalid with bresp=2'b11 until bready, then return to IDLE.
REQ-029 In LOC_RD, the block SHALL assert arready for one cycle, then rvalid with rresp=2'b11 and rdata=32'h0 until rready, then return to IDLE.
REQ-030 When CL_AXIL_ARB_DECERR_EN is undefined, every request SHALL be forwarded, no address compare logic SHALL exist, and ADDR_BASE/ADDR_SIZE SHALL be unused.

Verification
REQ-031 Case 1 (single write): s0 write to 0x10 with data 0xA5A5_0001 and wstrb 4'hF -> m_axi_bus sees the same values one cycle after the request; the slave's bresp=0 returns to s0; grant=01 throughout; busy returns to 0.
REQ-032 Case 2 (simultaneous reads): s0 and s1 both read from reset -> s0 is served first, then s1; a second simultaneous pair is served s0 then s1 again (alternation); rdata goes to the correct requester.
REQ-033 Case 3 (write and read from one requester): s1 presents a write and a read together -> the write completes fully before m_arvalid rises.
REQ-034 Case 4 (skewed write channels): awvalid rises 3 cycles before wvalid, and the slave accepts W before AW -> exactly one AW and one W handshake downstream, then WR_RESP.
REQ-035 Case 5 (reset mid-operation): reset asserted in RD_RESP while rvalid is held low -> next cycle is IDLE, all outputs 0, last_gnt=1.
REQ-036 Case 6 (out-of-window access, with CL_AXIL_ARB_DECERR_EN): with ADDR_SIZE=0x1000, a read from 0x2000 -> rresp=2'b11 and rdata=0, and m_arvalid is never asserted.
